// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin search used by the mux_4x1 arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] req_idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // First set bit of mask, searching upward from last+1 and wrapping; last itself is checked last.
    function automatic req_idx_t rr_next(input logic [NUM_REQ-1:0] mask, input req_idx_t last);
        req_idx_t idx;
        req_idx_t win;
        logic     found;
        win   = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = req_idx_t'(int'(last) + i);
            if (!found && mask[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mux_4x1.sv
// Plain 4:1 single-bit multiplexer; {sel1, sel0} picks i00..i11.
module mux_4x1 (
    input  logic i00,
    input  logic i01,
    input  logic i10,
    input  logic i11,
    input  logic sel0,
    input  logic sel1,
    output logic out
);

    assign out = sel1 ? (sel0 ? i11 : i10) : (sel0 ? i01 : i00);

endmodule

// File: rtl/mux_4x1_arbiter.sv
// Round-robin arbiter sharing one mux_4x1 among four single-bit producers.
// Define MUX_ARB_HOLD_LIMIT_EN to cap an owner's tenure at MAX_HOLD cycles while others wait.
module mux_4x1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] d,
    output logic [NUM_REQ-1:0] gnt,
    output logic               sel0,
    output logic               sel1,
    output logic               out,
    output logic               valid
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("MAX_HOLD must be in 1..255");
    end

    arb_state_e         r_state;
    req_idx_t           r_last;
    req_idx_t           r_sel;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_valid;

    logic [NUM_REQ-1:0] w_owner_mask;
    logic [NUM_REQ-1:0] w_others;
    logic               w_timeout;
    logic               w_take;
    logic               w_go_idle;
    req_idx_t           w_win;

`ifdef MUX_ARB_HOLD_LIMIT_EN
    logic [7:0] r_hold;
    // >= rather than == so a counter already saturated still yields once a competitor shows up.
    assign w_timeout = (r_hold >= 8'(MAX_HOLD - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_owner_mask = 4'b0001 << r_last;
    assign w_others     = req & ~w_owner_mask;

    always_comb begin
        w_take    = 1'b0;
        w_go_idle = 1'b0;
        w_win     = rr_next(req, r_last);
        case (r_state)
            IDLE: w_take = |req;
            GRANT: begin
                if (req[r_last] && !w_timeout) begin
                    w_take = 1'b0;
                end else if (|w_others) begin
                    w_take = 1'b1;
                    w_win  = rr_next(w_others, r_last);
                end else if (!req[r_last]) begin
                    w_go_idle = 1'b1;
                end
            end
            default: w_go_idle = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_last  <= 2'd3;
            r_sel   <= 2'd0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
            r_hold  <= 8'd0;
`endif
        end else if (w_take) begin
            r_state <= GRANT;
            r_last  <= w_win;
            r_sel   <= w_win;
            r_gnt   <= 4'b0001 << w_win;
            r_valid <= 1'b1;
`ifdef MUX_ARB_HOLD_LIMIT_EN
            r_hold  <= 8'd0;
`endif
        end else if (w_go_idle) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_valid <= 1'b0;
        end else if (r_state == GRANT) begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
            if (r_hold != 8'(MAX_HOLD))
                r_hold <= r_hold + 8'd1;
`endif
        end
    end

    assign gnt   = r_gnt;
    assign sel0  = r_sel[0];
    assign sel1  = r_sel[1];
    assign valid = r_valid;

    mux_4x1 u_mux (
        .i00  (d[0]),
        .i01  (d[1]),
        .i10  (d[2]),
        .i11  (d[3]),
        .sel0 (sel0),
        .sel1 (sel1),
        .out  (out)
    );

endmodule

// File: tb/tb_mux_4x1_arbiter.sv
// Self-checking bench for mux_4x1_arbiter: vector table, hand sequences, and a randomized run against a model.
module tb_mux_4x1_arbiter;

    localparam int MAX_HOLD = 2;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic       sel0;
    logic       sel1;
    logic       out;
    logic       valid;

    int checks = 0;
    int errors = 0;

    mux_4x1_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .d       (d),
        .gnt     (gnt),
        .sel0    (sel0),
        .sel1    (sel1),
        .out     (out),
        .valid   (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MUX_ARB_HOLD_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    // Reference model: who owns the mux and for how many cycles so far.
    bit m_busy;
    int m_owner;
    int m_sel;
    int m_cycles;

    function automatic int search(input logic [3:0] mask, input int from);
        for (int off = 1; off <= 4; off++) begin
            if (mask[(from + off) % 4])
                return (from + off) % 4;
        end
        return from;
    endfunction

    task automatic model_reset();
        m_busy   = 1'b0;
        m_owner  = 3;
        m_sel    = 0;
        m_cycles = 0;
    endtask

    task automatic model_take(input int k);
        m_busy   = 1'b1;
        m_owner  = k;
        m_sel    = k;
        m_cycles = 1;
    endtask

    task automatic model_edge(input logic [3:0] r);
        logic [3:0] others;
        bit         keeps;
        others = r;
        others[m_owner] = 1'b0;
        if (!m_busy) begin
            if (r != 4'b0000)
                model_take(search(r, m_owner));
        end else begin
            keeps = r[m_owner] && !(LIMIT && others != 4'b0000 && m_cycles >= MAX_HOLD);
            if (keeps)
                m_cycles++;
            else if (others != 4'b0000)
                model_take(search(others, m_owner));
            else
                m_busy = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [3:0] eg;
        logic [1:0] es;
        es = 2'(m_sel);
        eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        chk({tag, " gnt"},   {4'b0, gnt},          {4'b0, eg});
        chk({tag, " sel"},   {6'b0, sel1, sel0},   {6'b0, es});
        chk({tag, " valid"}, {7'b0, valid},        {7'b0, m_busy});
        chk({tag, " out"},   {7'b0, out},          {7'b0, d[es]});
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] dd);
        req = r;
        d   = dd;
        @(posedge clk);
        model_edge(r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 4'b0000;
        d       = 4'b0000;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] d;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       out;
        logic       valid;
    } vec_t;

    vec_t tbl[10];
    int   exp_own[10];

    initial begin
        tbl[0] = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
        tbl[1] = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
        tbl[2] = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
        tbl[3] = '{4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
        tbl[4] = '{4'b0000, 4'b0111, 4'b0000, 2'd3, 1'b0, 1'b0};
        tbl[5] = '{4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0};
        tbl[6] = '{4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[7] = '{4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b1};
        tbl[8] = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
        tbl[9] = '{4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};
`ifdef MUX_ARB_HOLD_LIMIT_EN
        exp_own = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
`else
        exp_own = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

        reset_n = 1'b0;
        req     = 4'b0000;
        d       = 4'b0001;
        #1;
        chk("reset gnt",   {4'b0, gnt},        8'h00);
        chk("reset sel",   {6'b0, sel1, sel0}, 8'h00);
        chk("reset valid", {7'b0, valid},      8'h00);
        chk("reset out",   {7'b0, out},        8'h01);
        do_reset();

        // Directed vectors, one clock edge each.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].req, tbl[i].d);
            chk($sformatf("vec%0d gnt", i),   {4'b0, gnt},        {4'b0, tbl[i].gnt});
            chk($sformatf("vec%0d sel", i),   {6'b0, sel1, sel0}, {6'b0, tbl[i].sel});
            chk($sformatf("vec%0d out", i),   {7'b0, out},        {7'b0, tbl[i].out});
            chk($sformatf("vec%0d valid", i), {7'b0, valid},      {7'b0, tbl[i].valid});
        end

        // All four requesting: rotation under the hold limit, otherwise owner 0 keeps it.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, 4'($urandom_range(0, 15)));
            chk($sformatf("rot%0d gnt", i), {4'b0, gnt}, 8'(1 << exp_own[i]));
            chk($sformatf("rot%0d out", i), {7'b0, out}, {7'b0, d[exp_own[i]]});
        end
        step(4'b1110, 4'b0010);
        chk("drop0 gnt", {4'b0, gnt}, 8'h02);

        // Asynchronous reset in the middle of a grant, between clock edges.
        #2 reset_n = 1'b0;
        d = 4'b0001;
        #1;
        chk("async gnt",   {4'b0, gnt},        8'h00);
        chk("async sel",   {6'b0, sel1, sel0}, 8'h00);
        chk("async valid", {7'b0, valid},      8'h00);
        chk("async out",   {7'b0, out},        8'h01);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        step(4'b1111, 4'b0000);
        chk("restart gnt", {4'b0, gnt}, 8'h01);

        // Every d pattern under every grant.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(4'(1 << k), 4'b0000);
            chk($sformatf("sweep%0d gnt", k), {4'b0, gnt}, 8'(1 << k));
            for (int p = 0; p < 16; p++) begin
                d = 4'(p);
                #1;
                chk($sformatf("sweep%0d d=%0h out", k, p), {7'b0, out}, {7'b0, d[k]});
            end
        end

        // Randomized traffic against the model; requests tend to persist.
        do_reset();
        begin
            logic [3:0] r;
            r = 4'b0000;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 3) == 0)
                    r = 4'($urandom_range(0, 15));
                else if ($urandom_range(0, 3) == 0)
                    r[$urandom_range(0, 3)] = ~r[$urandom_range(0, 3)];
                step(r, 4'($urandom_range(0, 15)));
                chk_model($sformatf("rnd%0d", i));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
